// File: rtl/flopd_pkg.sv
// flopd_pkg -- shared definitions for the flopd round-robin register arbiter.
//   state_t   : arbiter FSM state encoding (IDLE, GRANT, LOCKED)
//   DEF_*     : default parameter values used by the interface and modules
//   idx_w()   : width of a requester index (at least one bit)
package flopd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_WIDTH    = 4;
   localparam int DEF_MAX_HOLD = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/flopd_rr_arbiter_if.sv
// flopd_rr_arbiter_if -- requester-side bundle of the shared-register arbiter.
//   req     : per-requester request, held until gnt is seen
//   lock    : per-requester hold request (only the owner's bit matters)
//   data    : requester i data at data[i*WIDTH +: WIDTH]
//   gnt     : one-hot registered grant
//   q       : shared register contents
//   q_owner : index of the requester that last loaded q
//   q_valid : q holds granted data since reset
// Modports: master = requesting logic, slave = arbiter.
interface flopd_rr_arbiter_if
   import flopd_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
);
   localparam int OW = idx_w(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ-1:0]       lock;
   logic [N_REQ*WIDTH-1:0] data;
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       q;
   logic [OW-1:0]          q_owner;
   logic                   q_valid;

   modport master (output req, lock, data, input gnt, q, q_owner, q_valid);
   modport slave  (input req, lock, data, output gnt, q, q_owner, q_valid);

endinterface

// File: rtl/flopd_en.sv
// flopd_en -- WIDTH-bit D-register with load enable and asynchronous
// active-low clear.
//   clock : register clock
//   reset : asynchronous clear, active-low
//   en    : load enable
//   d     : data to load
//   q     : register contents
module flopd_en
   import flopd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/flopd_rr_arbiter.sv
// flopd_rr_arbiter -- shares one WIDTH-bit register among N_REQ requesters.
// A round-robin FSM grants one requester at a time and loads its data into
// the shared flopd_en register; a locked owner may load up to MAX_HOLD
// consecutive times before the grant moves on.
//   clock : single clock, posedge
//   reset : asynchronous, active-low
//   bus   : requester bundle (slave side): req/lock/data in, gnt/q/q_owner/q_valid out
module flopd_rr_arbiter
   import flopd_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic         clock,
   input  logic         reset,
   flopd_rr_arbiter_if.slave bus
);

   localparam int OW = idx_w(N_REQ);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD);
   localparam logic [OW-1:0]    LAST_IDX  = OW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
   localparam bit               CAN_LOCK  = (MAX_HOLD > 1);

   typedef logic [OW-1:0] idx_t;

   state_t           state;
   idx_t             ptr;
   idx_t             g;
   idx_t             g_next;
   idx_t             pick;
   logic             pick_ok;
   logic [HW-1:0]    hold_cnt;
   logic [HW-1:0]    hold_inc;
   logic [N_REQ-1:0] gnt_r;
   idx_t             owner_r;
   logic             valid_r;
   logic             own_req;
   logic             own_lock;
   logic             load;
   logic [WIDTH-1:0] d_sel;

   // First set request scanning upward from ptr with wrap. The loop runs from
   // the farthest offset down so the nearest one is the last to be written.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[(int'(ptr) + i) % N_REQ]) begin
            pick    = idx_t'((int'(ptr) + i) % N_REQ);
            pick_ok = 1'b1;
         end
      end
   end

   assign own_req  = bus.req[g];
   assign own_lock = bus.lock[g];
   assign hold_inc = hold_cnt + HW'(1);
   assign g_next   = (g == LAST_IDX) ? '0 : g + idx_t'(1);
   assign d_sel    = bus.data[int'(g)*WIDTH +: WIDTH];
   // The register loads only while the owner still requests; a dropped
   // request in GRANT cancels without touching q.
   assign load     = ((state == GRANT) || (state == LOCKED)) && own_req;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         gnt_r    <= '0;
         ptr      <= '0;
         g        <= '0;
         hold_cnt <= '0;
         owner_r  <= '0;
         valid_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_ok) begin
                  g        <= pick;
                  gnt_r    <= ONE_HOT0 << pick;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end else begin
                  gnt_r <= '0;
               end
            end
            GRANT: begin
               if (!own_req) begin
                  gnt_r <= '0;
                  state <= IDLE;
               end else begin
                  hold_cnt <= HW'(1);
                  owner_r  <= g;
                  valid_r  <= 1'b1;
                  if (own_lock && CAN_LOCK) begin
                     state <= LOCKED;
                  end else begin
                     gnt_r <= '0;
                     ptr   <= g_next;
                     state <= IDLE;
                  end
               end
            end
            LOCKED: begin
               if (own_req) begin
                  hold_cnt <= hold_inc;
                  owner_r  <= g;
               end
               // The load that reaches MAX_HOLD is the last one of this grant.
               if (!own_req || !own_lock || (hold_inc == HOLD_LAST)) begin
                  gnt_r <= '0;
                  ptr   <= g_next;
                  state <= IDLE;
               end
            end
            default: begin
               gnt_r <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   flopd_en #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (load),
      .d     (d_sel),
      .q     (bus.q)
   );

   assign bus.gnt     = gnt_r;
   assign bus.q_owner = owner_r;
   assign bus.q_valid = valid_r;

endmodule
